// File: rtl/cordic_req_bridge.sv
// Purpose : queues Q16.16 requests, runs the CORDIC engine's enable/done protocol, returns tagged results.
// Latency : pop one edge after a push into an empty FIFO; rsp_valid the cycle after the sampled cor_done rise.
// Backpr. : req_ready drops while the FIFO is full; a held response (rsp_ready low) stalls the FSM but not pushes.
//
// Ports:
//   clk, rst                  clock and synchronous active-low reset
//   req_valid/req_ready       request handshake carrying req_op, req_x/y/z, req_tag
//   rsp_valid/rsp_ready       response handshake carrying rsp_result, rsp_tag, rsp_err
//   cor_enable/cor_operation  engine start pulse and op code; cor_x/y/z engine operands
//   cor_result/cor_done       engine result and completion flag
//
// Optional feature: define CORDIC_BRIDGE_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles,
// after which an error response (result 0) is returned.
module cordic_req_bridge #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic [WIDTH-1:0] req_z,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             cor_enable,
    output logic [2:0]       cor_operation,
    output logic [WIDTH-1:0] cor_x,
    output logic [WIDTH-1:0] cor_y,
    output logic [WIDTH-1:0] cor_z,
    input  logic [WIDTH-1:0] cor_result,
    input  logic             cor_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Reject unusable parameter sets at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("cordic_req_bridge: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t             fifo_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             req_ready_q;
    logic             push;
    logic             pop;
    req_t             wr_entry;
    req_t             head;

    state_t           state_q;

    assign push     = req_valid & req_ready_q;
    // No bypass: only entries already stored at the start of the cycle can be popped.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head     = fifo_mem_q[rd_ptr_q];
    assign wr_entry = '{op: req_op, x: req_x, y: req_y, z: req_z, tag: req_tag};

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            req_ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Engine sequencing FSM (all outputs registered)
    // ------------------------------------------------------------------
    logic             done_q;
    logic             cor_enable_q;
    logic [2:0]       cor_op_q;
    logic [WIDTH-1:0] cor_x_q;
    logic [WIDTH-1:0] cor_y_q;
    logic [WIDTH-1:0] cor_z_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             done_rise;

`ifdef CORDIC_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt_q;
`endif

    // Only a fresh rise counts; a done level held over from an earlier op is ignored.
    assign done_rise = cor_done & ~done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            cor_enable_q <= 1'b0;
            cor_op_q     <= '0;
            cor_x_q      <= '0;
            cor_y_q      <= '0;
            cor_z_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            done_q       <= cor_done;
            cor_enable_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        rsp_tag_q <= head.tag;
                        if (head.op < 3'd6) begin
                            // Operands only move on a valid op, so the engine pins
                            // stay untouched by invalid requests.
                            cor_op_q     <= head.op;
                            cor_x_q      <= head.x;
                            cor_y_q      <= head.y;
                            cor_z_q      <= head.z;
                            cor_enable_q <= 1'b1;
                            state_q      <= S_START;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                S_WAIT: begin
                    if (done_rise) begin
                        rsp_result_q <= cor_result;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
`ifdef CORDIC_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TO_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_err       = rsp_err_q;
    assign cor_enable    = cor_enable_q;
    assign cor_operation = cor_op_q;
    assign cor_x         = cor_x_q;
    assign cor_y         = cor_y_q;
    assign cor_z         = cor_z_q;

endmodule
